// File: rtl/snn_debug_probe_if.sv
// Debug probe bundle: SNN-core observation inputs and the debug output bus.
// master drives the observed signals and config; slave is the probe itself.
interface snn_debug_probe_if #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned POT_W     = 6,
  parameter int unsigned N_L1      = 8,
  parameter int unsigned N_L2      = 8,
  parameter int unsigned OUT_W     = 8
);
  logic                         en;
  logic [7:0]                   cfg_in;
  logic [N_NEURONS*POT_W-1:0]   membrane_potentials;
  logic [N_L1-1:0]              spikes_l1;
  logic [N_L2-1:0]              spikes_l2;
  logic                         timestep_done;
  logic [OUT_W-1:0]             debug_output;
  logic                         debug_valid;
  logic                         frame_start;
  logic                         triggered;
  logic                         overrun;

  modport master (
    output en, cfg_in, membrane_potentials, spikes_l1, spikes_l2, timestep_done,
    input  debug_output, debug_valid, frame_start, triggered, overrun
  );

  modport slave (
    input  en, cfg_in, membrane_potentials, spikes_l1, spikes_l2, timestep_done,
    output debug_output, debug_valid, frame_start, triggered, overrun
  );
endinterface

// File: rtl/snn_debug_probe.sv
// SNN debug probe: static select, timestep snapshot, full-frame scan and
// spike-triggered capture of membrane potentials / spike vectors.
module snn_debug_probe #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned POT_W     = 6,
  parameter int unsigned N_L1      = 8,
  parameter int unsigned N_L2      = 8,
  parameter int unsigned OUT_W     = 8
) (
  input logic              clk,
  input logic              rst,
  snn_debug_probe_if.slave bus
);
  localparam logic [1:0] ModeStatic = 2'b00;
  localparam logic [1:0] ModeSnap   = 2'b01;
  localparam logic [1:0] ModeScan   = 2'b10;
  localparam logic [1:0] ModeTrig   = 2'b11;
  localparam logic [0:0] StIdle     = 1'b0;
  localparam logic [0:0] StStream   = 1'b1;

  localparam int unsigned PotsW   = N_NEURONS * POT_W;
  localparam logic [5:0]  NIdx    = 6'(N_NEURONS);
  localparam logic [5:0]  LastIdx = 6'(N_NEURONS + 1);

  logic [7:0]       cfg_q, cfg_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             trig_q, trig_d;
  logic             ovr_q, ovr_d;
  logic [0:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [PotsW-1:0] sh_pots_q, sh_pots_d;
  logic [N_L1-1:0]  sh_l1_q, sh_l1_d;
  logic [N_L2-1:0]  sh_l2_q, sh_l2_d;

  logic [1:0]       mode;
  logic [5:0]       idx;
  logic [5:0]       trig_idx;
  logic             watched_hit;
  logic [OUT_W-1:0] trig_word;

  // Word k of the frame: potentials first, then L1 spikes, anything beyond is L2.
  function automatic logic [OUT_W-1:0] sel_word(input logic [5:0]       k,
                                                input logic [PotsW-1:0] pots,
                                                input logic [N_L1-1:0]  l1,
                                                input logic [N_L2-1:0]  l2);
    logic [OUT_W-1:0] w;
    if (k == NIdx) w = OUT_W'(l1);
    else           w = OUT_W'(l2);
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      if (k == 6'(i)) w = OUT_W'(pots[i*POT_W +: POT_W]);
    end
    return w;
  endfunction

  assign mode        = cfg_q[7:6];
  assign idx         = cfg_q[5:0];
  assign trig_idx    = {1'b0, idx[5:1]};
  assign watched_hit = idx[0] ? |bus.spikes_l2 : |bus.spikes_l1;
  assign trig_word   = (trig_idx < NIdx) ?
                       sel_word(trig_idx, bus.membrane_potentials, '0, '0) : '0;

  always_comb begin
    cfg_d     = cfg_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    fs_d      = fs_q;
    trig_d    = trig_q;
    ovr_d     = ovr_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_pots_d = sh_pots_q;
    sh_l1_d   = sh_l1_q;
    sh_l2_d   = sh_l2_q;
    if (bus.en) begin
      // Config load aborts everything and leaves the last word on the pins.
      cfg_d   = bus.cfg_in;
      trig_d  = 1'b0;
      ovr_d   = 1'b0;
      valid_d = 1'b0;
      fs_d    = 1'b0;
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (mode)
        ModeStatic: begin
          dout_d  = sel_word(idx, bus.membrane_potentials, bus.spikes_l1, bus.spikes_l2);
          valid_d = 1'b0;
          fs_d    = 1'b0;
        end
        ModeSnap: begin
          valid_d = bus.timestep_done;
          fs_d    = 1'b0;
          if (bus.timestep_done) begin
            dout_d = sel_word(idx, bus.membrane_potentials, bus.spikes_l1, bus.spikes_l2);
          end
        end
        ModeScan: begin
          valid_d = 1'b0;
          fs_d    = 1'b0;
          if (state_q == StStream) begin
            dout_d  = sel_word(cnt_q, sh_pots_q, sh_l1_q, sh_l2_q);
            valid_d = 1'b1;
            fs_d    = (cnt_q == '0);
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == LastIdx) state_d = StIdle;
            if (bus.timestep_done) ovr_d = 1'b1;
          end else if (bus.timestep_done) begin
            sh_pots_d = bus.membrane_potentials;
            sh_l1_d   = bus.spikes_l1;
            sh_l2_d   = bus.spikes_l2;
            cnt_d     = '0;
            state_d   = StStream;
          end
        end
        ModeTrig: begin
          valid_d = 1'b0;
          fs_d    = 1'b0;
          if (bus.timestep_done && !trig_q && watched_hit) begin
            dout_d  = trig_word;
            valid_d = 1'b1;
            trig_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      trig_q    <= 1'b0;
      ovr_q     <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      sh_pots_q <= '0;
      sh_l1_q   <= '0;
      sh_l2_q   <= '0;
    end else begin
      cfg_q     <= cfg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
      trig_q    <= trig_d;
      ovr_q     <= ovr_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_pots_q <= sh_pots_d;
      sh_l1_q   <= sh_l1_d;
      sh_l2_q   <= sh_l2_d;
    end
  end

  assign bus.debug_output = dout_q;
  assign bus.debug_valid  = valid_q;
  assign bus.frame_start  = fs_q;
  assign bus.triggered    = trig_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_snn_debug_probe.sv
// Self-checking bench for snn_debug_probe: vector table, directed corner
// sequences and a random phase against a queue-based frame model.
module tb_snn_debug_probe;
  localparam int unsigned N   = 16;
  localparam int unsigned PW  = 6;
  localparam int unsigned NL1 = 8;
  localparam int unsigned NL2 = 8;
  localparam int unsigned OW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_debug_probe_if #(.N_NEURONS(N), .POT_W(PW), .N_L1(NL1), .N_L2(NL2), .OUT_W(OW)) bus ();

  snn_debug_probe #(.N_NEURONS(N), .POT_W(PW), .N_L1(NL1), .N_L2(NL2), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] pot [N];

  typedef struct { logic [OW-1:0] data; bit first; } word_t;
  word_t q[$];
  logic [7:0]    m_cfg;
  logic [OW-1:0] m_dout;
  logic          m_valid, m_fs, m_trig, m_ovr;

  typedef struct { logic [7:0] cfg; logic [7:0] exp; } svec_t;
  svec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pots();
    for (int i = 0; i < int'(N); i++) bus.membrane_potentials[i*PW +: PW] = pot[i];
  endtask

  function automatic logic [OW-1:0] ref_sel(input int k);
    if (k < int'(N))  return OW'(pot[k]);
    if (k == int'(N)) return OW'(bus.spikes_l1);
    return OW'(bus.spikes_l2);
  endfunction

  task automatic model_reset();
    m_cfg = '0; m_dout = '0; m_valid = 0; m_fs = 0; m_trig = 0; m_ovr = 0;
    q.delete();
  endtask

  // Expected register state after the coming edge, from the current inputs.
  task automatic model_edge();
    int  p;
    bit  hit;
    word_t w;
    if (bus.en) begin
      m_cfg = bus.cfg_in; m_trig = 0; m_ovr = 0; m_valid = 0; m_fs = 0;
      q.delete();
      return;
    end
    case (m_cfg[7:6])
      2'd0: begin m_dout = ref_sel(int'(m_cfg[5:0])); m_valid = 0; m_fs = 0; end
      2'd1: begin
        m_valid = bus.timestep_done; m_fs = 0;
        if (bus.timestep_done) m_dout = ref_sel(int'(m_cfg[5:0]));
      end
      2'd2: begin
        if (q.size() > 0) begin
          w = q.pop_front();
          m_dout = w.data; m_valid = 1; m_fs = w.first;
          if (bus.timestep_done) m_ovr = 1;
        end else begin
          m_valid = 0; m_fs = 0;
          if (bus.timestep_done)
            for (int k = 0; k < int'(N) + 2; k++) q.push_back('{data: ref_sel(k), first: (k == 0)});
        end
      end
      default: begin
        p   = int'(m_cfg[5:1]);
        hit = m_cfg[0] ? (bus.spikes_l2 != 0) : (bus.spikes_l1 != 0);
        m_valid = 0; m_fs = 0;
        if (bus.timestep_done && !m_trig && hit) begin
          m_dout = (p < int'(N)) ? OW'(pot[p]) : '0;
          m_valid = 1; m_trig = 1;
        end
      end
    endcase
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_dout"},  32'(bus.debug_output), 32'(m_dout));
    chk({tag, "_valid"}, 32'(bus.debug_valid),  32'(m_valid));
    chk({tag, "_fs"},    32'(bus.frame_start),  32'(m_fs));
    chk({tag, "_trig"},  32'(bus.triggered),    32'(m_trig));
    chk({tag, "_ovr"},   32'(bus.overrun),      32'(m_ovr));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cmp_all("model");
  endtask

  task automatic load_cfg(input logic [7:0] c);
    bus.en = 1'b1; bus.cfg_in = c;
    cycle();
    bus.en = 1'b0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < int'(N); i++) pot[i] = PW'(i + 1);
    drive_pots();
    bus.spikes_l1 = 8'hA5; bus.spikes_l2 = 8'h3C;
  endtask

  function automatic logic [7:0] ramp_word(input int j);
    if (j < int'(N))  return 8'(j + 1);
    if (j == int'(N)) return 8'hA5;
    return 8'h3C;
  endfunction

  initial begin
    tbl[0] = '{cfg: 8'h03, exp: 8'h2A};
    tbl[1] = '{cfg: 8'h00, exp: 8'h01};
    tbl[2] = '{cfg: 8'h0F, exp: 8'h10};
    tbl[3] = '{cfg: 8'h10, exp: 8'hA5};
    tbl[4] = '{cfg: 8'h11, exp: 8'h3C};
    tbl[5] = '{cfg: 8'h3F, exp: 8'h3C};

    rst = 1'b1;
    bus.en = 1'b0; bus.cfg_in = '0; bus.timestep_done = 1'b0;
    set_ramp();
    pot[3] = 6'h2A; drive_pots();
    model_reset();
    #1;
    cmp_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Static mode vector table, including out-of-range indices.
    foreach (tbl[i]) begin
      load_cfg(tbl[i].cfg);
      cycle();
      chk("static_dout", 32'(bus.debug_output), 32'(tbl[i].exp));
      chk("static_valid", 32'(bus.debug_valid), 32'd0);
    end

    // Snapshot: capture potential 5 only on the pulse, hold afterwards.
    load_cfg(8'h45);
    for (int j = 0; j <= 12; j++) begin
      pot[5] = PW'(j + 8); drive_pots();
      bus.timestep_done = (j == 9);
      cycle();
      if (j == 9) begin
        chk("snap_dout", 32'(bus.debug_output), 32'h11);
        chk("snap_valid", 32'(bus.debug_valid), 32'd1);
      end else if (j > 9) begin
        chk("snap_hold", 32'(bus.debug_output), 32'h11);
        chk("snap_valid_low", 32'(bus.debug_valid), 32'd0);
      end
    end
    bus.timestep_done = 1'b0;

    // Scan: full frame from shadow copy while live inputs change.
    set_ramp();
    load_cfg(8'h80);
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    bus.spikes_l1 = 8'h00; pot[0] = 6'h3F; drive_pots();
    for (int j = 0; j < int'(N) + 2; j++) begin
      cycle();
      chk("scan_word", 32'(bus.debug_output), 32'(ramp_word(j)));
      chk("scan_valid", 32'(bus.debug_valid), 32'd1);
      chk("scan_fs", 32'(bus.frame_start), 32'(j == 0));
    end
    cycle();
    chk("scan_idle_valid", 32'(bus.debug_valid), 32'd0);

    // Overrun: pulse during word 7, frame continues unchanged.
    set_ramp();
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    for (int j = 0; j < int'(N) + 2; j++) begin
      bus.timestep_done = (j == 7);
      cycle();
      chk("ovr_word", 32'(bus.debug_output), 32'(ramp_word(j)));
    end
    bus.timestep_done = 1'b0;
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    cycle();
    chk("ovr_no_refire", 32'(bus.debug_valid), 32'd0);

    // Abort by config load at word 4.
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    for (int j = 0; j < 4; j++) cycle();
    chk("abort_ovr_before", 32'(bus.overrun), 32'd1);
    load_cfg(8'h80);
    chk("abort_valid", 32'(bus.debug_valid), 32'd0);
    chk("abort_ovr", 32'(bus.overrun), 32'd0);
    cycle();
    chk("abort_idle", 32'(bus.debug_valid), 32'd0);

    // Trigger on L2, capture neuron 2.
    pot[2] = 6'h07; drive_pots();
    bus.spikes_l2 = 8'h00; bus.spikes_l1 = 8'hFF;
    load_cfg(8'hC5);
    for (int j = 0; j < 3; j++) begin
      bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
      chk("trig_none_valid", 32'(bus.debug_valid), 32'd0);
      chk("trig_none_flag", 32'(bus.triggered), 32'd0);
      cycle();
    end
    bus.spikes_l2 = 8'h01;
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    chk("trig_dout", 32'(bus.debug_output), 32'h07);
    chk("trig_valid", 32'(bus.debug_valid), 32'd1);
    chk("trig_flag", 32'(bus.triggered), 32'd1);
    cycle();
    chk("trig_valid_pulse", 32'(bus.debug_valid), 32'd0);
    pot[2] = 6'h15; drive_pots(); bus.spikes_l2 = 8'hFF;
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    chk("trig_frozen_dout", 32'(bus.debug_output), 32'h07);
    chk("trig_frozen_valid", 32'(bus.debug_valid), 32'd0);

    // Out-of-range trigger neuron captures zero.
    load_cfg(8'hE1);
    chk("trig_reload_clear", 32'(bus.triggered), 32'd0);
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    chk("trig_oor_dout", 32'(bus.debug_output), 32'h00);
    chk("trig_oor_valid", 32'(bus.debug_valid), 32'd1);

    // Asynchronous reset in the middle of a frame.
    set_ramp();
    load_cfg(8'h80);
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    for (int j = 0; j < 5; j++) cycle();
    #3 rst = 1'b1;
    #1;
    model_reset();
    cmp_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    load_cfg(8'h80);
    bus.timestep_done = 1'b1; cycle(); bus.timestep_done = 1'b0;
    cycle();
    chk("post_rst_first", 32'(bus.debug_output), 32'h01);
    chk("post_rst_fs", 32'(bus.frame_start), 32'd1);
    for (int j = 1; j < int'(N) + 3; j++) cycle();

    // Random phase against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.en = ($urandom_range(0, 24) == 0);
      bus.cfg_in = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      for (int i = 0; i < int'(N); i++) pot[i] = PW'($urandom);
      drive_pots();
      bus.spikes_l1 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      bus.spikes_l2 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      bus.timestep_done = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snn_debug_probe.md
Name: snn_debug_probe

Overview:
Parametrised debug observation block for the SNN core. It selects membrane potentials or layer spike vectors for the shared debug pins. Beyond static selection, it can snapshot at timestep boundaries, stream a full frame of every potential plus both spike vectors, and arm a spike-triggered capture. It sits beside the two neuron layers and drives the chip's debug output bus.

Parameters:
N_NEURONS, 16, number of membrane potentials in the flattened input; legal range 1..61.
POT_W, 6, width of each membrane potential; must be at most OUT_W.
N_L1, 8, layer-1 spike vector width; must be at most OUT_W.
N_L2, 8, layer-2 spike vector width; must be at most OUT_W.
OUT_W, 8, debug output word width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  load cfg_in into the config register
cfg_in  in  8  config: [7:6] mode, [5:0] index
membrane_potentials  in  N_NEURONS*POT_W  flattened; neuron i occupies [i*POT_W +: POT_W]
spikes_l1  in  N_L1  layer-1 output spikes
spikes_l2  in  N_L2  layer-2 output spikes
timestep_done  in  1  single-cycle pulse at the end of each SNN timestep
debug_output  out  OUT_W  registered debug word
debug_valid  out  1  debug_output holds a fresh word (used in modes 01, 10 and 11)
frame_start  out  1  high with the first word of a scan frame
triggered  out  1  trigger mode has fired; sticky
overrun  out  1  timestep_done arrived while a scan was in progress; sticky

Behaviour:
- Reset:
  - cfg, debug_output, debug_valid, frame_start, triggered and overrun are all 0.
  - The FSM is in IDLE and the scan counter is 0.
- Word selection function sel(k):
  - k < N_NEURONS: potential k, zero-extended to OUT_W.
  - k == N_NEURONS: spikes_l1, zero-extended.
  - k > N_NEURONS: spikes_l2, zero-extended.
- Config load:
  - en=1 loads cfg on the clock edge.
  - The load clears triggered, overrun, debug_valid and frame_start, and forces the FSM to IDLE. This aborts any scan in progress.
  - The cycle in which en=1 produces no output update from the old mode.
- Mode 00, STATIC:
  - Every cycle, debug_output <= sel(cfg index). Latency is 1 cycle from an input change.
  - debug_valid stays 0.
- Mode 01, SNAPSHOT:
  - On timestep_done: debug_output <= sel(index), and debug_valid pulses for 1 cycle.
  - debug_output holds between pulses.
- Mode 10, SCAN:
  - FSM states are IDLE and STREAM.
  - IDLE, on timestep_done:
    - All potentials and both spike vectors are latched into shadow registers.
    - Go to STREAM with counter = 0.
  - STREAM, each cycle:
    - debug_output <= shadow word(counter), debug_valid = 1, frame_start = (counter == 0).
    - Counter increments.
  - After word N_NEURONS+1 (the layer-2 spikes), return to IDLE. Frame length is N_NEURONS+2 consecutive valid cycles.
  - The first word appears the cycle after the capture cycle.
  - timestep_done while in STREAM is ignored for capture and sets overrun. The current frame continues unchanged.
  - timestep_done in the same cycle as the final word is also an overrun. A new frame starts only from IDLE.
- Mode 11, TRIGGER:
  - index[0] selects the watched layer: 0 = L1, 1 = L2. index[5:1] selects the neuron potential to capture.
  - Fires on the first timestep_done where the watched spike vector is nonzero and triggered = 0. Then:
    - debug_output <= potential index[5:1], zero-extended.
    - debug_valid pulses for 1 cycle.
    - triggered is set to 1.
  - Once triggered=1, the block is frozen: no further captures until cfg is reloaded.
- Out-of-range index:
  - Index > N_NEURONS+1 in modes 00 and 01 selects spikes_l2.
  - Index[5:1] >= N_NEURONS in mode 11 captures 0.
- Asynchronous reset mid-scan immediately returns all outputs to 0 and the FSM to IDLE.

Test Plan:
- Static mode, defaults: reset; load cfg 0x03 with potential 3 = 6'h2A -> debug_output = 8'h2A one cycle later, debug_valid = 0. Load cfg 0x10 -> spikes_l1; load cfg 0x3F -> spikes_l2.
- Snapshot: cfg 0x45 with potential 5 changing every cycle; pulse timestep_done when potential 5 = 6'h11 -> 8'h11 with a 1-cycle debug_valid. The value holds until the next pulse.
- Scan: cfg 0x80, potentials i = i+1, spikes_l1 = 8'hA5, spikes_l2 = 8'h3C, one pulse -> 18 valid cycles carrying 01..10, A5, 3C. frame_start is high only on the first word; IDLE afterwards.
- Scan overrun and abort: second pulse at word 7 -> frame completes unchanged and overrun = 1. A new cfg load at word 4 of a later frame -> valid drops, overrun clears.
- Trigger: cfg 0xC5 (L2, neuron 2 = 6'h07); pulses with spikes_l2 = 0 give no capture. A pulse with spikes_l2 = 8'h01 -> output 8'h07, valid pulse, triggered = 1. Later pulses change nothing.
- Reset asserted asynchronously mid-scan -> all outputs 0 in the same cycle; the next pulse after release starts a clean frame.
